// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop bank counter.
// Mode encodings used by the top level and by anything driving it.
package tff_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

endpackage

// File: rtl/tff_bank_counter_if.sv
// Control/status bundle of the T flip-flop bank counter.
// master drives controls and observes state; slave is the counter.
interface tff_bank_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, t, load, d,
    input  q, qb, tc, wrap
  );

  modport slave (
    input  en, mode, t, load, d,
    output q, qb, tc, wrap
  );

endinterface

// File: rtl/tff_cell.sv
// Single-bit T flip-flop with synchronous active-low reset.
// Parallel load wins over toggle.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q,
  output logic qb
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= RST_VAL;
    end else if (ld) begin
      r_q <= d;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/tff_bank_counter.sv
// Bank of T cells: hold, per-bit toggle, up/down count, load,
// optional saturation and a registered wrap pulse.
module tff_bank_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  tff_bank_counter_if.slave   bus
);

  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;
  logic [WIDTH-1:0] w_tv;
  logic [WIDTH-1:0] w_tog;
  logic             w_all1;
  logic             w_all0;
  logic             w_is_tg;
  logic             w_is_up;
  logic             w_is_dn;
  logic             w_adv;
  logic             w_wrap_nxt;
  logic             r_wrap;

  // Bit i toggles when all lower bits are ones (up) / zeros (down)
  always_comb begin
    logic [WIDTH-1:0] msk;
    w_up = '0;
    w_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      msk     = (WIDTH'(1) << i) - WIDTH'(1);
      w_up[i] = &(w_q | ~msk);
      w_dn[i] = ~|(w_q & msk);
    end
  end

  assign w_all1  = &w_q;
  assign w_all0  = ~|w_q;
  assign w_is_tg = (bus.mode == MODE_TOGGLE);
  assign w_is_up = (bus.mode == MODE_UP);
  assign w_is_dn = (bus.mode == MODE_DOWN);
  assign w_adv   = bus.en & ~bus.load;

  always_comb begin
    w_tv = '0;
    unique case (1'b1)
      w_is_tg: w_tv = bus.t;
      w_is_up: w_tv = (SAT && w_all1) ? '0 : w_up;
      w_is_dn: w_tv = (SAT && w_all0) ? '0 : w_dn;
      default: w_tv = '0;
    endcase
  end

  assign w_tog = w_adv ? w_tv : '0;

  assign w_wrap_nxt = !SAT && w_adv &&
                      ((w_is_up && w_all1) ||
                       (w_is_dn && w_all0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell #(
      .RST_VAL (RST_VAL[gi])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .ld  (bus.load),
      .d   (bus.d[gi]),
      .t   (w_tog[gi]),
      .q   (w_q[gi]),
      .qb  (w_qb[gi])
    );
  end

  assign bus.q    = w_q;
  assign bus.qb   = w_qb;
  assign bus.tc   = (w_is_up & w_all1) | (w_is_dn & w_all0);
  assign bus.wrap = r_wrap;

endmodule
